serial_pattern_tx: RTL

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

---
 rtl/serial_pattern_pkg.sv | 23 ++
 rtl/serial_pattern_tx.sv | 135 +++++++++++++
 2 files changed

// File: rtl/serial_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter.
// This file holds the state encoding, the default sizing and the repeat-count helper.
package serial_pattern_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int GAP_DEFAULT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Index of the last repetition; a requested count of 0 behaves like 1.
  function automatic logic [3:0] rep_last(input logic [3:0] rep);
    if (rep == 4'd0) begin
      return 4'd0;
    end else begin
      return rep - 4'd1;
    end
  endfunction

endpackage

// File: rtl/serial_pattern_tx.sv
// Serial word transmitter: shifts a captured word MSB first, repeats it,
// then pulses done and holds an idle gap before accepting the next load.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int GAP   = GAP_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       rep,
  input  logic             load,
  output logic             ready,
  output logic             out,
  output logic             active,
  output logic             done
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  BIT_ONE  = CW'(1);
  localparam logic [3:0]     GAP_LAST = 4'(GAP - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       rep_cnt_q, rep_cnt_d;
  logic [3:0]       rep_last_q, rep_last_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             out_q, out_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  // State, counters, data word and output flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      rep_cnt_q  <= 4'd0;
      rep_last_q <= 4'd0;
      gap_cnt_q  <= 4'd0;
      out_q      <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      rep_last_q <= rep_last_d;
      gap_cnt_q  <= gap_cnt_d;
      out_q      <= out_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output decode.
  // The data word rotates left one place per payload bit, so after WIDTH
  // rotations it is back in its captured form and bit WIDTH-2 of the rotated
  // word is always the next bit to send, including the wrap to a new repetition.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    bit_cnt_d  = bit_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    rep_last_d = rep_last_q;
    gap_cnt_d  = gap_cnt_q;
    out_d      = 1'b0;
    active_d   = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          data_d     = data_in;
          rep_last_d = rep_last(rep);
          bit_cnt_d  = '0;
          rep_cnt_d  = 4'd0;
          gap_cnt_d  = 4'd0;
          out_d      = data_in[WIDTH-1];
          active_d   = 1'b1;
          state_d    = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        if (bit_cnt_q != BIT_LAST) begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
          out_d     = data_q[WIDTH-2];
          active_d  = 1'b1;
        end else if (rep_cnt_q != rep_last_q) begin
          bit_cnt_d = '0;
          rep_cnt_d = rep_cnt_q + 4'd1;
          out_d     = data_q[WIDTH-2];
          active_d  = 1'b1;
        end else begin
          bit_cnt_d = '0;
          gap_cnt_d = 4'd0;
          done_d    = 1'b1;
          if (GAP > 0) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        // The done cycle is the first of the GAP idle cycles.
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = 4'd0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready  = (state_q == ST_IDLE);
  assign out    = out_q;
  assign active = active_q;
  assign done   = done_q;

endmodule
